heartbeat_checker: RTL and testbench

Receive-side companion to the test-board LED blink generator. Samples an asynchronous blink/heartbeat line (the LED net from another board, or the MCU heartbeat pin) and measures its rising-edge-to-rising-edge period in clk cycles. Checks each period against a nominal value with tolerance, and declares the link healthy after N consecutive good periods. Drives a status LED or MCU-readable flags in the board self-test.

---
 rtl/heartbeat_checker.sv | 174 +++++++++++++++++
 tb/tb_heartbeat_checker.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/heartbeat_checker.sv
// heartbeat_checker
//   Measures the rise-to-rise period of an asynchronous heartbeat line in clk
//   cycles. Each period is checked against NOM_PERIOD +/- TOL. The link is
//   declared healthy after GOOD_N consecutive good periods with no failure.
//   A missing edge (no rise within NOM_PERIOD+TOL cycles) is a timeout failure.
//
// Ports
//   clk           system clock
//   nreset        asynchronous active-low reset
//   hb_in         asynchronous heartbeat input (only rising edges matter)
//   clear         synchronous clear of status, measurement and streak
//   period        last measured period in cycles (holds across clear)
//   period_valid  one-cycle pulse when period updates
//   hb_ok         GOOD_N consecutive good periods seen, no failure since
//   hb_fail       sticky out-of-range / timeout flag
//   good_cnt      count of in-tolerance periods, saturating at 255
module heartbeat_checker #(
  parameter int NOM_PERIOD = 2097152,
  parameter int TOL        = 65536,
  parameter int GOOD_N     = 3,
  parameter int CNT_W      = 22
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             hb_in,
  input  logic             clear,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             hb_ok,
  output logic             hb_fail,
  output logic [7:0]       good_cnt
);

  // Lower limit clamps at zero when the tolerance exceeds the nominal period.
  localparam int               LO_INT   = (TOL > NOM_PERIOD) ? 0 : NOM_PERIOD - TOL;
  localparam logic [CNT_W-1:0] LO_LIM   = CNT_W'(LO_INT);
  localparam logic [CNT_W-1:0] HI_LIM   = CNT_W'(NOM_PERIOD + TOL);
  localparam logic [3:0]       GOOD_TGT = 4'(GOOD_N);

  typedef enum logic {
    WAIT_EDGE = 1'b0,
    MEASURE   = 1'b1
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [3:0] streak_inc(input logic [3:0] v);
    return (v >= GOOD_TGT) ? GOOD_TGT : v + 4'd1;
  endfunction

  logic             s1_q, s2_q, s3_q;
  logic             rise;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             pv_q, pv_d;
  logic [3:0]       streak_q, streak_d;
  logic [7:0]       good_q, good_d;
  logic             fail_q, fail_d;
  logic             ok_q, ok_d;

  logic             in_range;
  logic             at_limit;

  // ---- input synchronizer and edge history (not affected by clear) ----
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= hb_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise     = s2_q & ~s3_q;
  assign in_range = (cnt_q >= LO_LIM) && (cnt_q <= HI_LIM);
  assign at_limit = (cnt_q == HI_LIM);

  // ---- FSM state register ----
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= WAIT_EDGE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- FSM next state ----
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = WAIT_EDGE;
    end else if (state_q == WAIT_EDGE) begin
      if (rise) state_d = MEASURE;
    end else begin
      // A rise on the limit cycle wins over the timeout.
      if (!rise && at_limit) state_d = WAIT_EDGE;
    end
  end

  // ---- FSM outputs / datapath next state ----
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    pv_d     = 1'b0;
    streak_d = streak_q;
    good_d   = good_q;
    fail_d   = fail_q;
    ok_d     = (streak_q == GOOD_TGT) & ~fail_q;

    if (clear) begin
      // A rise in this cycle is deliberately dropped; period is kept.
      cnt_d    = '0;
      streak_d = '0;
      good_d   = '0;
      fail_d   = 1'b0;
      ok_d     = 1'b0;
    end else if (state_q == WAIT_EDGE) begin
      // First edge only arms the measurement.
      cnt_d = rise ? CNT_W'(1) : '0;
    end else if (rise) begin
      cnt_d    = CNT_W'(1);
      period_d = cnt_q;
      pv_d     = 1'b1;
      if (in_range) begin
        streak_d = streak_inc(streak_q);
        good_d   = sat_inc8(good_q);
      end else begin
        streak_d = '0;
        fail_d   = 1'b1;
      end
    end else if (at_limit) begin
      // Timeout: period is left untouched, measurement re-arms.
      cnt_d    = '0;
      streak_d = '0;
      fail_d   = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ---- status / measurement registers ----
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q    <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      streak_q <= '0;
      good_q   <= '0;
      fail_q   <= 1'b0;
      ok_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      streak_q <= streak_d;
      good_q   <= good_d;
      fail_q   <= fail_d;
      ok_q     <= ok_d;
    end
  end

  assign period       = period_q;
  assign period_valid = pv_q;
  assign hb_ok        = ok_q;
  assign hb_fail      = fail_q;
  assign good_cnt     = good_q;

endmodule

// File: tb/tb_heartbeat_checker.sv
// Testbench for heartbeat_checker with NOM_PERIOD=100, TOL=5, GOOD_N=3, CNT_W=8.
// Stimulus pushes the expected {period, good_cnt, hb_fail} for every period
// that should be reported; a monitor pops one entry per period_valid pulse.
module tb_heartbeat_checker;

  localparam int NOM   = 100;
  localparam int TOLV  = 5;
  localparam int GN    = 3;
  localparam int CW    = 8;

  logic          clk;
  logic          nreset;
  logic          hb_in;
  logic          clear;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          hb_ok;
  logic          hb_fail;
  logic [7:0]    good_cnt;

  typedef struct {
    int period;
    int gc;
    int fail;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  heartbeat_checker #(
    .NOM_PERIOD(NOM),
    .TOL       (TOLV),
    .GOOD_N    (GN),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .nreset      (nreset),
    .hb_in       (hb_in),
    .clear       (clear),
    .period      (period),
    .period_valid(period_valid),
    .hb_ok       (hb_ok),
    .hb_fail     (hb_fail),
    .good_cnt    (good_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int p, input int gc, input int f);
    exp_t e;
    e.period = p;
    e.gc     = gc;
    e.fail   = f;
    exp_q.push_back(e);
  endtask

  // One rising edge on hb_in followed by p cycles of ~50% duty square wave.
  task automatic hb_cycle(input int p);
    hb_in = 1'b1;
    repeat (p / 2) @(negedge clk);
    hb_in = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (period_valid === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_period_valid: period=%0d good_cnt=%0d hb_fail=%0d, none expected",
                 period, good_cnt, hb_fail);
      end else begin
        mon_e = exp_q.pop_front();
        if (int'(period) !== mon_e.period || int'(good_cnt) !== mon_e.gc ||
            int'(hb_fail) !== mon_e.fail) begin
          n_fail++;
          $display("FAIL period_report: got period=%0d good_cnt=%0d hb_fail=%0d, expected period=%0d good_cnt=%0d hb_fail=%0d",
                   period, good_cnt, hb_fail, mon_e.period, mon_e.gc, mon_e.fail);
        end
      end
    end
  end

  initial begin
    nreset = 1'b0;
    hb_in  = 1'b0;
    clear  = 1'b0;

    // Reset / idle
    repeat (3) @(negedge clk);
    chk("rst_period", int'(period), 0);
    chk("rst_hb_ok", int'(hb_ok), 0);
    chk("rst_hb_fail", int'(hb_fail), 0);
    chk("rst_good_cnt", int'(good_cnt), 0);
    nreset = 1'b1;
    repeat (300) @(negedge clk);
    chk("idle_hb_fail", int'(hb_fail), 0);
    chk("idle_period", int'(period), 0);
    chk("idle_pv", int'(period_valid), 0);
    chk("idle_good_cnt", int'(good_cnt), 0);

    // Nominal lock
    hb_cycle(100);
    push(100, 1, 0); hb_cycle(100);
    push(100, 2, 0); hb_cycle(100);
    push(100, 3, 0);
    hb_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("lock_pv_now", int'(period_valid), 1);
    chk("lock_hb_ok_pre", int'(hb_ok), 0);
    @(negedge clk);
    chk("lock_hb_ok", int'(hb_ok), 1);
    chk("lock_good_cnt", int'(good_cnt), 3);
    repeat (46) @(negedge clk);
    hb_in = 1'b0;
    repeat (50) @(negedge clk);

    // Tolerance edges
    pulse_clear();
    chk("clr_good_cnt", int'(good_cnt), 0);
    chk("clr_hb_ok", int'(hb_ok), 0);
    chk("clr_period_hold", int'(period), 100);
    hb_cycle(95);
    push(95, 1, 0);  hb_cycle(105);
    push(105, 2, 0); hb_cycle(94);
    push(94, 2, 1);  hb_cycle(100);
    chk("tol_hb_fail", int'(hb_fail), 1);
    chk("tol_hb_ok", int'(hb_ok), 0);
    chk("tol_period", int'(period), 94);
    chk("tol_good_cnt", int'(good_cnt), 2);

    // Timeout
    pulse_clear();
    hb_cycle(100);
    push(100, 1, 0); hb_cycle(100);
    push(100, 2, 0); hb_cycle(100);
    push(100, 3, 0);
    hb_in = 1'b1;
    repeat (50) @(negedge clk);
    hb_in = 1'b0;
    repeat (57) @(negedge clk);
    chk("tmo_fail_pre", int'(hb_fail), 0);
    chk("tmo_ok_pre", int'(hb_ok), 1);
    @(negedge clk);
    chk("tmo_fail", int'(hb_fail), 1);
    @(negedge clk);
    chk("tmo_ok", int'(hb_ok), 0);
    chk("tmo_period", int'(period), 100);
    repeat (10) @(negedge clk);
    hb_cycle(100);
    push(100, 4, 1); hb_cycle(100);
    chk("tmo_ok_sticky", int'(hb_ok), 0);
    chk("tmo_good_cnt", int'(good_cnt), 4);

    // Clear coinciding with a rise
    hb_in = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clrrise_fail", int'(hb_fail), 0);
    chk("clrrise_good_cnt", int'(good_cnt), 0);
    repeat (47) @(negedge clk);
    hb_in = 1'b0;
    repeat (50) @(negedge clk);
    hb_cycle(100);
    push(100, 1, 0);

    // Async reset mid-period
    hb_in = 1'b1;
    repeat (50) @(negedge clk);
    hb_in = 1'b0;
    chk("pre_rst_period", int'(period), 100);
    #1 nreset = 1'b0;
    #1;
    chk("arst_period", int'(period), 0);
    chk("arst_good_cnt", int'(good_cnt), 0);
    chk("arst_hb_ok", int'(hb_ok), 0);
    chk("arst_hb_fail", int'(hb_fail), 0);
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    repeat (5) @(negedge clk);

    // good_cnt saturation
    hb_cycle(100);
    for (int i = 1; i <= 260; i++) begin
      push(100, (i > 255) ? 255 : i, 0);
      hb_cycle(100);
    end
    chk("sat_good_cnt", int'(good_cnt), 255);
    chk("sat_hb_ok", int'(hb_ok), 1);
    chk("sat_hb_fail", int'(hb_fail), 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
